// File: rtl/stream_demux_pkg.sv
// Shared constants and helpers for the stream_demux block.
package stream_demux_pkg;

    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    function automatic int clog2_f(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/demux_dec.sv
// Select-to-one-hot decoder with an in-range flag; out-of-range selects decode to all zeros.
module demux_dec
    import stream_demux_pkg::*;
#(
    parameter int N_OUT = 2,
    parameter int SEL_W = 1
) (
    input  logic [SEL_W-1:0] sel,
    output logic [N_OUT-1:0] onehot,
    output logic             in_range
);

    always_comb begin
        // NOTE: default every output first so no path through the block leaves a latch behind.
        onehot   = '0;
        in_range = (int'(sel) < N_OUT);
        for (int i = 0; i < N_OUT; i++) begin
            if (sel == SEL_W'(i)) onehot[i] = 1'b1;
        end
    end

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-N stream demultiplexer with per-channel back-pressure.
// Optional drop counter port enabled by defining STREAM_DEMUX_DROP_CNT_EN.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_OUT = 2,
    parameter int SEL_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0] in_sel,
    output logic [N_OUT-1:0] out_valid,
    input  logic [N_OUT-1:0] out_ready,
    output logic [WIDTH-1:0] out_data,
`ifdef STREAM_DEMUX_DROP_CNT_EN
    output logic [15:0]      drop_cnt,
`endif
    output logic             drop
);

    if (N_OUT < 2 || N_OUT > 16 || SEL_W < clog2_f(N_OUT)) begin : g_param_check
        $error("stream_demux: N_OUT must be 2..16 and 2**SEL_W >= N_OUT");
    end

    logic             state;
    logic [WIDTH-1:0] held_data;
    logic [SEL_W-1:0] held_sel;
    logic             drop_q;

    logic [N_OUT-1:0] held_onehot;
    logic             held_in_range;
    logic [N_OUT-1:0] in_onehot;
    logic             in_range;

    demux_dec #(.N_OUT(N_OUT), .SEL_W(SEL_W)) u_held_dec (
        .sel      (held_sel),
        .onehot   (held_onehot),
        .in_range (held_in_range)
    );

    demux_dec #(.N_OUT(N_OUT), .SEL_W(SEL_W)) u_in_dec (
        .sel      (in_sel),
        .onehot   (in_onehot),
        .in_range (in_range)
    );

    logic pop;
    logic accept;

    // Ready flows straight through from the addressed sink so a pop and a push share one cycle.
    assign pop       = (state == ST_FULL) && |(out_ready & held_onehot);
    assign in_ready  = (state == ST_EMPTY) || pop;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == ST_FULL && held_in_range) ? held_onehot : '0;
    assign out_data  = held_data;
    assign drop      = drop_q;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state     <= ST_EMPTY;
            held_data <= '0;
            held_sel  <= '0;
            drop_q    <= 1'b0;
        end else begin
            drop_q <= accept && !in_range;
            if (accept && in_range) begin
                state     <= ST_FULL;
                held_data <= in_data;
                held_sel  <= in_sel;
            end else if (pop) begin
                state <= ST_EMPTY;
            end
        end
    end

`ifdef STREAM_DEMUX_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop_q && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Directed self-checking bench for stream_demux (two instances: N_OUT=2 and N_OUT=3).
module tb_stream_demux;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       v2 = 1'b0;
    logic       rdy2;
    logic [7:0] d2 = '0;
    logic [0:0] s2 = '0;
    logic [1:0] ov2;
    logic [1:0] or2 = '0;
    logic [7:0] od2;
    logic       drop2;

    logic       v3 = 1'b0;
    logic       rdy3;
    logic [7:0] d3 = '0;
    logic [1:0] s3 = '0;
    logic [2:0] ov3;
    logic [2:0] or3 = '0;
    logic [7:0] od3;
    logic       drop3;
`ifdef STREAM_DEMUX_DROP_CNT_EN
    logic [15:0] cnt2;
    logic [15:0] cnt3;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    stream_demux #(.WIDTH(8), .N_OUT(2), .SEL_W(1)) u_dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v2),
        .in_ready  (rdy2),
        .in_data   (d2),
        .in_sel    (s2),
        .out_valid (ov2),
        .out_ready (or2),
        .out_data  (od2),
`ifdef STREAM_DEMUX_DROP_CNT_EN
        .drop_cnt  (cnt2),
`endif
        .drop      (drop2)
    );

    stream_demux #(.WIDTH(8), .N_OUT(3), .SEL_W(2)) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v3),
        .in_ready  (rdy3),
        .in_data   (d3),
        .in_sel    (s3),
        .out_valid (ov3),
        .out_ready (or3),
        .out_data  (od3),
`ifdef STREAM_DEMUX_DROP_CNT_EN
        .drop_cnt  (cnt3),
`endif
        .drop      (drop3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tests++; if (ov2 !== 2'b00) begin fails++; $display("FAIL reset_ov2 got %b exp 00", ov2); end
        tests++; if (rdy2 !== 1'b1) begin fails++; $display("FAIL reset_rdy2 got %b exp 1", rdy2); end
        tests++; if (drop2 !== 1'b0) begin fails++; $display("FAIL reset_drop2 got %b exp 0", drop2); end
        tests++; if (od2 !== 8'h00) begin fails++; $display("FAIL reset_od2 got %h exp 00", od2); end
        tests++; if (ov3 !== 3'b000) begin fails++; $display("FAIL reset_ov3 got %b exp 000", ov3); end
        tests++; if (drop3 !== 1'b0) begin fails++; $display("FAIL reset_drop3 got %b exp 0", drop3); end
`ifdef STREAM_DEMUX_DROP_CNT_EN
        tests++; if (cnt3 !== 16'h0) begin fails++; $display("FAIL reset_cnt3 got %h exp 0000", cnt3); end
`endif
    endtask

    task automatic test_single();
        or2 = 2'b11;
        v2 = 1'b1; d2 = 8'hA5; s2 = 1'b1;
        tests++; if (rdy2 !== 1'b1) begin fails++; $display("FAIL single_rdy got %b exp 1", rdy2); end
        tick();
        v2 = 1'b0;
        tests++; if (ov2 !== 2'b10) begin fails++; $display("FAIL single_ov got %b exp 10", ov2); end
        tests++; if (od2 !== 8'hA5) begin fails++; $display("FAIL single_od got %h exp a5", od2); end
        tick();
        tests++; if (ov2 !== 2'b00) begin fails++; $display("FAIL single_empty got %b exp 00", ov2); end
    endtask

    task automatic test_backpressure();
        or2 = 2'b10;
        v2 = 1'b1; d2 = 8'h3C; s2 = 1'b0;
        tick();
        // A competing beat is offered during the stall and must not disturb the held one.
        d2 = 8'h11; s2 = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tests++; if (ov2 !== 2'b01) begin fails++; $display("FAIL bp_ov[%0d] got %b exp 01", c, ov2); end
            tests++; if (od2 !== 8'h3C) begin fails++; $display("FAIL bp_od[%0d] got %h exp 3c", c, od2); end
            tests++; if (rdy2 !== 1'b0) begin fails++; $display("FAIL bp_rdy[%0d] got %b exp 0", c, rdy2); end
            tick();
        end
        or2 = 2'b11;
        #1;
        tests++; if (rdy2 !== 1'b1) begin fails++; $display("FAIL bp_release_rdy got %b exp 1", rdy2); end
        tick();
        v2 = 1'b0;
        tests++; if (ov2 !== 2'b10) begin fails++; $display("FAIL bp_next_ov got %b exp 10", ov2); end
        tests++; if (od2 !== 8'h11) begin fails++; $display("FAIL bp_next_od got %h exp 11", od2); end
        tick();
        tests++; if (ov2 !== 2'b00) begin fails++; $display("FAIL bp_drain got %b exp 00", ov2); end
    endtask

    task automatic test_stream();
        logic [1:0] exp_ov;
        or2 = 2'b11;
        for (int i = 1; i <= 8; i++) begin
            v2 = 1'b1; d2 = 8'(i); s2 = 1'((i - 1) % 2);
            exp_ov = (i % 2 == 1) ? 2'b01 : 2'b10;
            tests++; if (rdy2 !== 1'b1) begin fails++; $display("FAIL stream_rdy[%0d] got %b exp 1", i, rdy2); end
            tick();
            tests++; if (ov2 !== exp_ov) begin fails++; $display("FAIL stream_ov[%0d] got %b exp %b", i, ov2, exp_ov); end
            tests++; if (od2 !== 8'(i)) begin fails++; $display("FAIL stream_od[%0d] got %h exp %h", i, od2, 8'(i)); end
        end
        v2 = 1'b0;
        tick();
        tests++; if (ov2 !== 2'b00) begin fails++; $display("FAIL stream_end got %b exp 00", ov2); end
    endtask

    task automatic test_out_of_range();
        or3 = 3'b111;
        v3 = 1'b1; d3 = 8'hFF; s3 = 2'd3;
        tests++; if (rdy3 !== 1'b1) begin fails++; $display("FAIL oor_rdy got %b exp 1", rdy3); end
        tick();
        v3 = 1'b0;
        tests++; if (drop3 !== 1'b1) begin fails++; $display("FAIL oor_drop got %b exp 1", drop3); end
        tests++; if (ov3 !== 3'b000) begin fails++; $display("FAIL oor_ov got %b exp 000", ov3); end
        tick();
        tests++; if (drop3 !== 1'b0) begin fails++; $display("FAIL oor_drop_end got %b exp 0", drop3); end
        tests++; if (ov3 !== 3'b000) begin fails++; $display("FAIL oor_ov2 got %b exp 000", ov3); end
`ifdef STREAM_DEMUX_DROP_CNT_EN
        tests++; if (cnt3 !== 16'd1) begin fails++; $display("FAIL oor_cnt got %h exp 0001", cnt3); end
`endif
        // Valid beat to channel 2, then an out-of-range beat that pops it without storing.
        v3 = 1'b1; d3 = 8'h42; s3 = 2'd2;
        tick();
        d3 = 8'h99; s3 = 2'd3;
        tests++; if (ov3 !== 3'b100) begin fails++; $display("FAIL oor_ch2_ov got %b exp 100", ov3); end
        tests++; if (od3 !== 8'h42) begin fails++; $display("FAIL oor_ch2_od got %h exp 42", od3); end
        tests++; if (rdy3 !== 1'b1) begin fails++; $display("FAIL oor_ch2_rdy got %b exp 1", rdy3); end
        tick();
        v3 = 1'b0;
        tests++; if (ov3 !== 3'b000) begin fails++; $display("FAIL oor_pop_ov got %b exp 000", ov3); end
        tests++; if (drop3 !== 1'b1) begin fails++; $display("FAIL oor_pop_drop got %b exp 1", drop3); end
        tests++; if (od3 !== 8'h42) begin fails++; $display("FAIL oor_pop_od got %h exp 42", od3); end
        tick();
    endtask

    task automatic test_reset_mid();
        or2 = 2'b01;
        v2 = 1'b1; d2 = 8'h77; s2 = 1'b1;
        tick();
        v2 = 1'b0;
        tests++; if (ov2 !== 2'b10) begin fails++; $display("FAIL rmid_held_ov got %b exp 10", ov2); end
        tests++; if (rdy2 !== 1'b0) begin fails++; $display("FAIL rmid_held_rdy got %b exp 0", rdy2); end
        rst = 1'b1;
        v2 = 1'b1; d2 = 8'h55; s2 = 1'b0;
        tick();
        rst = 1'b0;
        v2 = 1'b0;
        tests++; if (ov2 !== 2'b00) begin fails++; $display("FAIL rmid_ov got %b exp 00", ov2); end
        tests++; if (rdy2 !== 1'b1) begin fails++; $display("FAIL rmid_rdy got %b exp 1", rdy2); end
        tests++; if (od2 !== 8'h00) begin fails++; $display("FAIL rmid_od got %h exp 00", od2); end
        tests++; if (drop2 !== 1'b0) begin fails++; $display("FAIL rmid_drop got %b exp 0", drop2); end
        or2 = 2'b11;
        for (int c = 0; c < 3; c++) begin
            tick();
            tests++; if (ov2 !== 2'b00) begin fails++; $display("FAIL rmid_after[%0d] got %b exp 00", c, ov2); end
        end
    endtask

`ifdef STREAM_DEMUX_DROP_CNT_EN
    task automatic test_saturation();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++; if (cnt3 !== 16'h0) begin fails++; $display("FAIL sat_clear got %h exp 0000", cnt3); end
        or3 = 3'b111;
        v3 = 1'b1; d3 = 8'hEE; s3 = 2'd3;
        repeat (65537) tick();
        v3 = 1'b0;
        tick();
        tick();
        tests++; if (cnt3 !== 16'hFFFF) begin fails++; $display("FAIL sat_cnt got %h exp ffff", cnt3); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_stream();
        test_out_of_range();
        test_reset_mid();
`ifdef STREAM_DEMUX_DROP_CNT_EN
        test_saturation();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
